// File: rtl/systolic_2x2_tile_ctrl.sv
// Sequencer for a 2x2 MAC systolic array: clears it, feeds a skewed A/B wavefront, drains, holds the result.
// Latency accept->out_valid = 4+DRAIN_CYCLES; one tile in flight; optional counters under SA_TILE_CTRL_PERF_EN.
module systolic_2x2_tile_ctrl #(
  parameter int WIDTH_A      = 16,
  parameter int WIDTH_B      = 16,
  parameter int WIDTH_OUT    = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [4*WIDTH_A-1:0]   in_a_i,
  input  logic [4*WIDTH_B-1:0]   in_b_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [4*WIDTH_OUT-1:0] out_c_o,
`ifdef SA_TILE_CTRL_PERF_EN
  output logic [31:0]            tile_count_o,
  output logic [31:0]            busy_cycles_o,
`endif
  output logic                   sa_rst_n_o,
  output logic                   sa_en_o,
  output logic [WIDTH_B-1:0]     sa_north0_o,
  output logic [WIDTH_B-1:0]     sa_north1_o,
  output logic [WIDTH_A-1:0]     sa_west0_o,
  output logic [WIDTH_A-1:0]     sa_west2_o,
  input  logic [4*WIDTH_OUT-1:0] sa_out_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_HOLD
  } state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t                 state_q;
  logic [1:0]             step_q;
  logic [3:0]             drain_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [4*WIDTH_OUT-1:0] out_c_q;
  logic [4*WIDTH_A-1:0]   a_q;
  logic [4*WIDTH_B-1:0]   b_q;
  logic                   sa_rst_n_q;
  logic                   sa_en_q;
  logic [WIDTH_B-1:0]     north0_q, north1_q;
  logic [WIDTH_A-1:0]     west0_q, west2_q;

  logic [1:0]             feed_step_d;
  logic [WIDTH_B-1:0]     north0_d, north1_d;
  logic [WIDTH_A-1:0]     west0_d, west2_d;

  logic [WIDTH_A-1:0]     a00, a01, a10, a11;
  logic [WIDTH_B-1:0]     b00, b01, b10, b11;
  logic                   in_hs;
  logic                   out_hs;

  assign a00 = a_q[4*WIDTH_A-1 -: WIDTH_A];
  assign a01 = a_q[3*WIDTH_A-1 -: WIDTH_A];
  assign a10 = a_q[2*WIDTH_A-1 -: WIDTH_A];
  assign a11 = a_q[WIDTH_A-1:0];
  assign b00 = b_q[4*WIDTH_B-1 -: WIDTH_B];
  assign b01 = b_q[3*WIDTH_B-1 -: WIDTH_B];
  assign b10 = b_q[2*WIDTH_B-1 -: WIDTH_B];
  assign b11 = b_q[WIDTH_B-1:0];

  assign in_hs  = in_valid_i && in_ready_q;
  assign out_hs = out_valid_q && out_ready_i;

  // Edge values for the step being entered: row 1 / column 1 lag by one cycle (skew).
  always_comb begin
    feed_step_d = (state_q == S_CLEAR) ? 2'd0 : step_q + 2'd1;
    north0_d    = '0;
    north1_d    = '0;
    west0_d     = '0;
    west2_d     = '0;
    case (feed_step_d)
      2'd0: begin
        north0_d = b00;
        west0_d  = a00;
      end
      2'd1: begin
        north0_d = b10;
        north1_d = b01;
        west0_d  = a01;
        west2_d  = a10;
      end
      2'd2: begin
        north1_d = b11;
        west2_d  = a11;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      drain_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sa_rst_n_q  <= 1'b0;
      sa_en_q     <= 1'b0;
      north0_q    <= '0;
      north1_q    <= '0;
      west0_q     <= '0;
      west2_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sa_rst_n_q <= 1'b1;
          sa_en_q    <= 1'b0;
          if (in_hs) begin
            a_q        <= in_a_i;
            b_q        <= in_b_i;
            in_ready_q <= 1'b0;
            sa_rst_n_q <= 1'b0;
            state_q    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          sa_rst_n_q <= 1'b1;
          sa_en_q    <= 1'b1;
          step_q     <= 2'd0;
          north0_q   <= north0_d;
          north1_q   <= north1_d;
          west0_q    <= west0_d;
          west2_q    <= west2_d;
          state_q    <= S_FEED;
        end
        S_FEED: begin
          if (step_q == 2'd2) begin
            step_q   <= 2'd0;
            drain_q  <= 4'd0;
            north0_q <= '0;
            north1_q <= '0;
            west0_q  <= '0;
            west2_q  <= '0;
            state_q  <= S_DRAIN;
          end else begin
            step_q   <= feed_step_d;
            north0_q <= north0_d;
            north1_q <= north1_d;
            west0_q  <= west0_d;
            west2_q  <= west2_d;
          end
        end
        S_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            out_c_q     <= sa_out_i;
            out_valid_q <= 1'b1;
            sa_en_q     <= 1'b0;
            drain_q     <= 4'd0;
            state_q     <= S_HOLD;
          end else begin
            drain_q <= drain_q + 4'd1;
          end
        end
        S_HOLD: begin
          if (out_hs) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          in_ready_q <= 1'b1;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SA_TILE_CTRL_PERF_EN
  logic [31:0] tile_count_q;
  logic [31:0] busy_cycles_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tile_count_q  <= '0;
      busy_cycles_q <= '0;
    end else begin
      if (out_hs) begin
        tile_count_q <= tile_count_q + 32'd1;
      end
      if (state_q != S_IDLE) begin
        busy_cycles_q <= busy_cycles_q + 32'd1;
      end
    end
  end

  assign tile_count_o  = tile_count_q;
  assign busy_cycles_o = busy_cycles_q;
`else
  // Counters and their ports are compiled out entirely.
`endif

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_c_o     = out_c_q;
  assign sa_rst_n_o  = sa_rst_n_q;
  assign sa_en_o     = sa_en_q;
  assign sa_north0_o = north0_q;
  assign sa_north1_o = north1_q;
  assign sa_west0_o  = west0_q;
  assign sa_west2_o  = west2_q;

endmodule

// File: tb/tb_systolic_2x2_tile_ctrl.sv
// Bench for systolic_2x2_tile_ctrl: a Q8.8 2x2 systolic array model is driven by the DUT edges,
// and expected tiles come from a direct matrix product pushed to a scoreboard queue.
module tb_systolic_2x2_tile_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_c;
  logic        sa_rst_n;
  logic        sa_en;
  logic [15:0] sa_north0, sa_north1, sa_west0, sa_west2;
  logic [63:0] sa_out;
`ifdef SA_TILE_CTRL_PERF_EN
  logic [31:0] tile_count;
  logic [31:0] busy_cycles;
`endif

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  systolic_2x2_tile_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_c_o      (out_c),
`ifdef SA_TILE_CTRL_PERF_EN
    .tile_count_o (tile_count),
    .busy_cycles_o(busy_cycles),
`endif
    .sa_rst_n_o   (sa_rst_n),
    .sa_en_o      (sa_en),
    .sa_north0_o  (sa_north0),
    .sa_north1_o  (sa_north1),
    .sa_west0_o   (sa_west0),
    .sa_west2_o   (sa_west2),
    .sa_out_i     (sa_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] q88(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    p = 32'(x) * 32'(y);
    return p[23:8];
  endfunction

  function automatic logic [63:0] pk(input logic [15:0] e0, input logic [15:0] e1,
                                     input logic [15:0] e2, input logic [15:0] e3);
    return {e0, e1, e2, e3};
  endfunction

  function automatic logic [63:0] ref_mm(input logic [63:0] a, input logic [63:0] b);
    logic [15:0] am[2][2];
    logic [15:0] bm[2][2];
    logic [63:0] c;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        am[i][j] = a[(63 - 16*(2*i+j)) -: 16];
        bm[i][j] = b[(63 - 16*(2*i+j)) -: 16];
      end
    end
    c = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        c[(63 - 16*(2*i+j)) -: 16] = q88(am[i][0], bm[0][j]) + q88(am[i][1], bm[1][j]);
      end
    end
    return c;
  endfunction

  // Array model: output-stationary PEs, A passes east, B passes south.
  logic [15:0] acc00, acc01, acc10, acc11, ah00, ah10, bv00, bv01;
  always @(posedge clk) begin
    if (sa_rst_n === 1'b0) begin
      acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
      ah00  <= '0; ah10  <= '0; bv00  <= '0; bv01  <= '0;
    end else if (sa_en === 1'b1) begin
      acc00 <= acc00 + q88(sa_west0, sa_north0);
      acc01 <= acc01 + q88(ah00, sa_north1);
      acc10 <= acc10 + q88(sa_west2, bv00);
      acc11 <= acc11 + q88(ah10, bv01);
      ah00  <= sa_west0;
      bv00  <= sa_north0;
      ah10  <= sa_west2;
      bv01  <= sa_north1;
    end
  end
  assign sa_out = {acc00, acc01, acc10, acc11};

  wire [63:0] edges = {sa_north0, sa_north1, sa_west0, sa_west2};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic pop_cmp(input string tag);
    logic [63:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    chk(tag, out_c, e);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    chk("accept_in_ready_low", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    int hits;
    logic [63:0] ta, tb, e;
    logic [63:0] edge_tab[6];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_c",     out_c,          64'(0));
    chk("rst_sa_rst_n",  64'(sa_rst_n),  64'(0));
    chk("rst_sa_en",     64'(sa_en),     64'(0));
    chk("rst_edges",     edges,          64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_sa_rst_n", 64'(sa_rst_n), 64'(1));
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Identity in Q8.8, consumer ready well before the result.
    out_ready = 1'b1;
    exp_q.push_back(pk(16'h0200, 16'h0300, 16'h0400, 16'h0500));
    send(pk(16'h0100, 16'h0000, 16'h0000, 16'h0100), pk(16'h0200, 16'h0300, 16'h0400, 16'h0500));
    wait_valid(n);
    chk("ident_latency", 64'(n), 64'(7));
    pop_cmp("ident_out_c");
    chk("ident_hold_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("ident_out_valid_fall", 64'(out_valid), 64'(0));
    chk("ident_in_ready_rise",  64'(in_ready),  64'(1));

    // Edge drive sequence with raw small integers.
    edge_tab[0] = pk(16'd5, 16'd0, 16'd1, 16'd0);
    edge_tab[1] = pk(16'd7, 16'd6, 16'd2, 16'd3);
    edge_tab[2] = pk(16'd0, 16'd8, 16'd0, 16'd4);
    edge_tab[3] = '0;
    edge_tab[4] = '0;
    edge_tab[5] = '0;
    chk("edge_pre_sa_rst_n", 64'(sa_rst_n), 64'(1));
    ta = pk(16'd1, 16'd2, 16'd3, 16'd4);
    tb = pk(16'd5, 16'd6, 16'd7, 16'd8);
    exp_q.push_back(ref_mm(ta, tb));
    send(ta, tb);
    chk("clear_sa_rst_n", 64'(sa_rst_n), 64'(0));
    chk("clear_sa_en",    64'(sa_en),    64'(0));
    chk("clear_edges",    edges,         64'(0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("feed_drain_edges",    edges,         edge_tab[i]);
      chk("feed_drain_sa_en",    64'(sa_en),    64'(1));
      chk("feed_drain_sa_rst_n", 64'(sa_rst_n), 64'(1));
      chk("feed_drain_no_valid", 64'(out_valid), 64'(0));
    end
    @(negedge clk);
    chk("edge_out_valid", 64'(out_valid), 64'(1));
    pop_cmp("edge_out_c");
    @(negedge clk);

    // Backpressure: result held for 10 cycles.
    out_ready = 1'b0;
    ta = pk(16'h0180, 16'h0040, 16'h0200, 16'h0100);
    tb = pk(16'h0100, 16'h0080, 16'h0300, 16'h0020);
    exp_q.push_back(ref_mm(ta, tb));
    send(ta, tb);
    wait_valid(n);
    chk("bp_latency", 64'(n), 64'(7));
    e = (exp_q.size() != 0) ? exp_q[0] : 64'hDEAD_DEAD_DEAD_DEAD;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_c_stable", out_c,           e);
      chk("bp_out_valid",    64'(out_valid),  64'(1));
      chk("bp_in_ready",     64'(in_ready),   64'(0));
      chk("bp_sa_en",        64'(sa_en),      64'(0));
      @(negedge clk);
    end
    pop_cmp("bp_out_c");
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out_valid_fall", 64'(out_valid), 64'(0));
    chk("bp_in_ready_rise",  64'(in_ready),  64'(1));

    // Back-to-back with in_valid held; second tile's data changes after the first accept.
    ta = pk(16'h0300, 16'h0100, 16'h0080, 16'h0240);
    tb = pk(16'h0200, 16'h0100, 16'h0100, 16'h0400);
    exp_q.push_back(ref_mm(ta, tb));
    in_a = ta; in_b = tb; in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_first_accept", 64'(in_ready), 64'(0));
    ta = pk(16'h0010, 16'h0500, 16'h0120, 16'h0001);
    tb = pk(16'h0700, 16'h0011, 16'h0003, 16'h0250);
    in_a = ta; in_b = tb;
    wait_valid(n);
    chk("b2b_first_latency", 64'(n), 64'(7));
    chk("b2b_hold_no_accept", 64'(in_ready), 64'(0));
    pop_cmp("b2b_first_out_c");
    exp_q.push_back(ref_mm(ta, tb));
    @(negedge clk);
    chk("b2b_hs_out_valid", 64'(out_valid), 64'(0));
    chk("b2b_hs_in_ready",  64'(in_ready),  64'(1));
    @(negedge clk);
    chk("b2b_second_accept", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
    in_a = '1; in_b = '1;
    wait_valid(n);
    chk("b2b_second_latency", 64'(n), 64'(7));
    pop_cmp("b2b_second_out_c");
    @(negedge clk);

    // Reset during FEED step1: tile discarded.
    send(pk(16'h0400, 16'h0400, 16'h0400, 16'h0400), pk(16'h0400, 16'h0400, 16'h0400, 16'h0400));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_sa_rst_n", 64'(sa_rst_n),  64'(0));
    chk("midrst_sa_en",    64'(sa_en),     64'(0));
    chk("midrst_in_ready", 64'(in_ready),  64'(1));
    chk("midrst_edges",    edges,          64'(0));
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) hits++;
      @(negedge clk);
    end
    chk("midrst_no_out_valid", 64'(hits), 64'(0));
    ta = pk(16'h0100, 16'h0200, 16'h0000, 16'h0080);
    tb = pk(16'h0030, 16'h0100, 16'h0200, 16'h0000);
    exp_q.push_back(ref_mm(ta, tb));
    send(ta, tb);
    wait_valid(n);
    chk("midrst_next_latency", 64'(n), 64'(7));
    pop_cmp("midrst_next_out_c");
    @(negedge clk);

    // A few random tiles.
    for (int t = 0; t < 3; t++) begin
      ta = {$urandom, $urandom};
      tb = {$urandom, $urandom};
      chk("rand_in_ready", 64'(in_ready), 64'(1));
      exp_q.push_back(ref_mm(ta, tb));
      send(ta, tb);
      wait_valid(n);
      chk("rand_latency", 64'(n), 64'(7));
      pop_cmp("rand_out_c");
      @(negedge clk);
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_2x2_tile_ctrl.md
# systolic_2x2_tile_ctrl

Sequencer for the 2x2 multiply-accumulate systolic array. Accepts one 2x2 A tile and one 2x2 B tile per transaction over a valid/ready handshake. Clears the array, drives the skewed operand wavefront onto its north/west edges, waits a fixed drain time, then captures the four results into a held output register under a second valid/ready handshake. Sits between the tile-fetch logic and the array instance in the matrix-multiply datapath.

## Interface
- WIDTH_A, 16, element width of A operands (west edge)
- WIDTH_B, 16, element width of B operands (north edge)
- WIDTH_OUT, 16, result element width
- DRAIN_CYCLES, 3, zero-feed cycles after FEED before capture (legal 1..15)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  tile pair present
- in_ready  out  1  block can accept a tile pair
- in_a  in  4*WIDTH_A  {a00,a01,a10,a11}, a00 in MSBs
- in_b  in  4*WIDTH_B  {b00,b01,b10,b11}, b00 in MSBs
- out_valid  out  1  result tile held
- out_ready  in  1  consumer accepts result
- out_c  out  4*WIDTH_OUT  {c00,c01,c10,c11}, registered
- sa_rst_n  out  1  active-low clear to array
- sa_en  out  1  array enable
- sa_north0, sa_north1  out  WIDTH_B  array north inputs
- sa_west0, sa_west2  out  WIDTH_A  array west inputs
- sa_out  in  4*WIDTH_OUT  array result bus, same packing as out_c

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, HOLD. A 2-bit step counter is used in FEED and a 4-bit counter in DRAIN.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch in_a/in_b into operand registers and go to CLEAR.
- CLEAR:
  - One cycle; sa_rst_n=0, sa_en=0, edge outputs 0.
  - Then FEED with step=0.
- FEED: three cycles, sa_en=1. Edge drive per step (north0, north1, west0, west2):
  - step0: b00, 0, a00, 0
  - step1: b10, b01, a01, a10
  - step2: 0, b11, 0, a11
  - After step2, go to DRAIN.
- DRAIN:
  - DRAIN_CYCLES cycles; sa_en=1, all edges 0.
  - On the edge ending the last DRAIN cycle, out_c<=sa_out and out_valid<=1. Go to HOLD.
- HOLD:
  - sa_en=0, edges 0; out_c stable.
  - On out_valid&&out_ready, out_valid<=0 and go to IDLE.
- in_ready=0 in every state except IDLE. Input is not back-pressured into the operand registers outside IDLE.
- sa_rst_n=1 in all states except CLEAR and while rst is high.
- All sa_* edge outputs are registered (driven from state and step, not from in_a/in_b directly).
- Arithmetic is done entirely in the array; this block only routes values and never truncates or extends them.

## Timing
- Reset (rst=1 at an edge):
  - state=IDLE, in_ready=1 on the next cycle, out_valid=0, out_c=0.
  - sa_rst_n=0 during rst, sa_en=0, edges 0, counters 0.
- Reset mid-operation (any state): the tile is discarded, no out_valid pulse, and the array is cleared via sa_rst_n.
- Latency from input accept edge to out_valid high: 1 (CLEAR) + 3 (FEED) + DRAIN_CYCLES cycles. This is 7 cycles at default.
- Throughput: one tile per 5+DRAIN_CYCLES cycles, plus HOLD stall cycles.
- out_ready high before out_valid has no effect.
- out_ready held high gives a single-cycle HOLD. in_ready rises the cycle after the output handshake.
- in_valid arriving in the same cycle out_ready completes HOLD is not accepted; it is accepted on the next cycle in IDLE.
- in_a/in_b are sampled only on the accept edge; later changes are ignored.

## Configuration
- SA_TILE_CTRL_PERF_EN:
  - Defined: adds output tile_count (32 bits, increments on each output handshake, wraps at 2^32) and output busy_cycles (32 bits, increments every cycle state!=IDLE, wraps). Both clear on rst.
  - Undefined: ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Reset release: rst high 2 cycles then low -> in_ready=1, out_valid=0, out_c=0, sa_rst_n=0 during rst then 1.
- Identity: A={1.0,0,0,1.0} (0x0100 each, Q8.8), B={0x0200,0x0300,0x0400,0x0500}, out_ready=1 -> out_valid exactly 7 cycles after accept, out_c={0x0200,0x0300,0x0400,0x0500}.
- Edge-drive check: A={1,2,3,4}, B={5,6,7,8} (raw) -> per-step sa_north0/north1/west0/west2 = (5,0,1,0),(7,6,2,3),(0,8,0,4); 3 DRAIN cycles of zeros; sa_rst_n low exactly one cycle before step0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_c stable, in_ready=0 throughout, sa_en=0; out_ready pulse -> out_valid falls next cycle, in_ready=1.
- Back-to-back: two tiles with in_valid held and out_ready=1 -> second accepted 1 cycle after first output handshake; second result unaffected by first (accumulators cleared).
- Reset mid-FEED: rst at step1 -> no out_valid; next tile produces a correct result with no residue.
